// File: rtl/mux_nto1_scan.sv
// Registered N:1 multiplexer with manual select and an auto-scan mode.
// In scan mode each channel is held for DWELL enabled cycles before the next one.
module mux_nto1_scan #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  output logic [SELW-1:0]      ch_out,
  output logic                 sel_err,
  output logic                 wrap
);

  localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int NSLOT = 2 ** SELW;
  localparam logic [SELW-1:0] LAST_CH    = SELW'(NCH - 1);
  localparam logic [DW-1:0]   LAST_DWELL = DW'(DWELL - 1);

  typedef enum logic {S_MAN, S_SCAN} state_t;

  state_t           state, state_nxt;
  logic [SELW-1:0]  ch, ch_nxt, cur_ch;
  logic [DW-1:0]    dwell, dwell_nxt, cur_dwell;
  logic [WIDTH-1:0] y_nxt;
  logic             y_valid_nxt, sel_err_nxt, wrap_nxt, sel_ok;
  logic [SELW-1:0]  ch_out_nxt;
  logic [WIDTH-1:0] chans [NSLOT];

  // Unused select slots read as zero so every index of the table is defined.
  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (k < NCH) begin : g_used
      assign chans[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chans[k] = '0;
    end
  end

  assign sel_ok = ({{(32-SELW){1'b0}}, sel} < 32'(NCH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_MAN;
      ch      <= '0;
      dwell   <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      ch_out  <= '0;
      sel_err <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      dwell   <= dwell_nxt;
      y       <= y_nxt;
      y_valid <= y_valid_nxt;
      ch_out  <= ch_out_nxt;
      sel_err <= sel_err_nxt;
      wrap    <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) state_nxt = mode ? S_SCAN : S_MAN;
  end

  // The entry edge into scan already serves channel 0 as its first dwell cycle.
  // Being in scan with both counters at zero only happens right after a wrap.
  always_comb begin
    y_nxt       = y;
    y_valid_nxt = y_valid;
    ch_out_nxt  = ch_out;
    sel_err_nxt = sel_err;
    wrap_nxt    = 1'b0;
    ch_nxt      = ch;
    dwell_nxt   = dwell;
    cur_ch      = (state == S_SCAN) ? ch : '0;
    cur_dwell   = (state == S_SCAN) ? dwell : '0;
    if (en) begin
      if (state_nxt == S_SCAN) begin
        y_nxt       = chans[cur_ch];
        y_valid_nxt = 1'b1;
        ch_out_nxt  = cur_ch;
        sel_err_nxt = 1'b0;
        wrap_nxt    = (state == S_SCAN) && (ch == '0) && (dwell == '0);
        if (cur_dwell == LAST_DWELL) begin
          dwell_nxt = '0;
          ch_nxt    = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
        end else begin
          dwell_nxt = cur_dwell + 1'b1;
          ch_nxt    = cur_ch;
        end
      end else begin
        ch_nxt    = '0;
        dwell_nxt = '0;
        if (sel_ok) begin
          y_nxt       = chans[sel];
          y_valid_nxt = 1'b1;
          ch_out_nxt  = sel;
          sel_err_nxt = 1'b0;
        end else begin
          y_valid_nxt = 1'b0;
          sel_err_nxt = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: two builds (NCH=4/DWELL=2 and NCH=3/DWELL=1) checked
// every cycle against a position-based scan model, plus directed literal checks.
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        en, mode;
  logic [1:0]  sel;

  logic [7:0] y_a, y_b;
  logic       y_valid_a, y_valid_b, sel_err_a, sel_err_b, wrap_a, wrap_b;
  logic [1:0] ch_out_a, ch_out_b;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic        in_scan;
    logic [31:0] pos;
    logic [7:0]  y;
    logic        valid;
    logic [1:0]  ch;
    logic        err;
    logic        wrap;
  } mstate_t;

  mstate_t ma, mb;

  mux_nto1_scan #(.WIDTH(8), .NCH(4), .SELW(2), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .mode(mode), .sel(sel),
    .y(y_a), .y_valid(y_valid_a), .ch_out(ch_out_a), .sel_err(sel_err_a), .wrap(wrap_a)
  );

  mux_nto1_scan #(.WIDTH(8), .NCH(3), .SELW(2), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din[23:0]), .en(en), .mode(mode), .sel(sel),
    .y(y_b), .y_valid(y_valid_b), .ch_out(ch_out_b), .sel_err(sel_err_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  // Scan position counts enabled scan edges since entry; channel and wrap follow by division.
  function automatic mstate_t step(mstate_t s, int nch, int dw, logic m,
                                   logic [1:0] sv, logic [31:0] d, logic e);
    mstate_t r;
    int c;
    r = s;
    r.wrap = 1'b0;
    if (e) begin
      if (m) begin
        if (!s.in_scan) begin
          r.in_scan = 1'b1;
          r.pos     = 0;
        end
        c       = (int'(r.pos) / dw) % nch;
        r.y     = d[c*8 +: 8];
        r.valid = 1'b1;
        r.ch    = 2'(c);
        r.err   = 1'b0;
        r.wrap  = (r.pos > 0) && ((int'(r.pos) % (dw * nch)) == 0);
        r.pos   = r.pos + 1;
      end else begin
        r.in_scan = 1'b0;
        if (int'(sv) < nch) begin
          r.y     = d[int'(sv)*8 +: 8];
          r.valid = 1'b1;
          r.ch    = sv;
          r.err   = 1'b0;
        end else begin
          r.valid = 1'b0;
          r.err   = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= step(ma, 4, 2, mode, sel, din, en);
      mb <= step(mb, 3, 1, mode, sel, din, en);
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_output("a_y",       32'(y_a),       32'(ma.y));
      check_output("a_y_valid", 32'(y_valid_a), 32'(ma.valid));
      check_output("a_ch_out",  32'(ch_out_a),  32'(ma.ch));
      check_output("a_sel_err", 32'(sel_err_a), 32'(ma.err));
      check_output("a_wrap",    32'(wrap_a),    32'(ma.wrap));
      check_output("b_y",       32'(y_b),       32'(mb.y));
      check_output("b_y_valid", 32'(y_valid_b), 32'(mb.valid));
      check_output("b_ch_out",  32'(ch_out_b),  32'(mb.ch));
      check_output("b_sel_err", 32'(sel_err_b), 32'(mb.err));
      check_output("b_wrap",    32'(wrap_b),    32'(mb.wrap));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic e, input logic m, input logic [1:0] s);
    en   = e;
    mode = m;
    sel  = s;
    tick();
  endtask

  logic [7:0] scan_exp [10];
  logic [7:0] sw_exp [4];

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    sel   = 2'd0;
    din   = 32'hD3C2B1A0;
    scan_exp = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hC2, 8'hC2, 8'hD3, 8'hD3, 8'hA0, 8'hA0};
    sw_exp   = '{8'hB1, 8'hA0, 8'hA0, 8'hB1};
    @(negedge clk);
    @(negedge clk);
    check_output("rst_y",       32'(y_a),       32'h00);
    check_output("rst_y_valid", 32'(y_valid_a), 32'h0);
    rst_n = 1'b1;

    // Manual select through every channel
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'(i));
      check_output("man_y",      32'(y_a),       32'(din[i*8 +: 8]));
      check_output("man_ch_out", 32'(ch_out_a),  32'(i));
      check_output("man_valid",  32'(y_valid_a), 32'h1);
    end

    // Scan across a full wrap
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b1, 2'd0);
      check_output("scan_y",    32'(y_a),    32'(scan_exp[i]));
      check_output("scan_wrap", 32'(wrap_a), (i == 8) ? 32'h1 : 32'h0);
    end

    // Freeze on the second cycle of channel 1
    apply_stimulus(1'b1, 1'b1, 2'd0);
    check_output("pre_freeze_y", 32'(y_a), 32'hB1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 2'd0);
      check_output("freeze_y",    32'(y_a),    32'hB1);
      check_output("freeze_wrap", 32'(wrap_a), 32'h0);
    end
    apply_stimulus(1'b1, 1'b1, 2'd0);
    check_output("unfreeze_y0", 32'(y_a), 32'hB1);
    apply_stimulus(1'b1, 1'b1, 2'd0);
    check_output("unfreeze_y1", 32'(y_a), 32'hC2);

    // Mode switch mid-dwell, scan restarts at channel 0
    apply_stimulus(1'b1, 1'b0, 2'd1);
    check_output("switch_y", 32'(y_a), 32'(sw_exp[0]));
    for (int i = 1; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b1, 2'd0);
      check_output("rescan_y", 32'(y_a), 32'(sw_exp[i]));
    end

    // Illegal select on the three-channel build
    apply_stimulus(1'b1, 1'b0, 2'd2);
    check_output("b_sel2_y", 32'(y_b), 32'hC2);
    apply_stimulus(1'b1, 1'b0, 2'd3);
    check_output("b_sel3_y",     32'(y_b),       32'hC2);
    check_output("b_sel3_valid", 32'(y_valid_b), 32'h0);
    check_output("b_sel3_err",   32'(sel_err_b), 32'h1);
    apply_stimulus(1'b1, 1'b0, 2'd0);
    check_output("b_sel0_y",     32'(y_b),       32'hA0);
    check_output("b_sel0_valid", 32'(y_valid_b), 32'h1);
    check_output("b_sel0_err",   32'(sel_err_b), 32'h0);

    // Asynchronous reset mid-scan, then scan from the first edge
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_y",       32'(y_a),       32'h00);
    check_output("async_y_valid", 32'(y_valid_a), 32'h0);
    check_output("async_ch_out",  32'(ch_out_a),  32'h0);
    check_output("async_wrap",    32'(wrap_a),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b1, 2'd0);
    check_output("post_rst_y", 32'(y_a), 32'hA0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) din = $urandom;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      en  = ($urandom_range(0, 7) != 0);
      sel = 2'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
